// File: rtl/mem_pipelined.sv
// Single-port word memory with a valid/ready request port, per-bit write mask,
// a RD_LAT-deep registered read pipeline, and an optional zero-fill sweep after reset.
module mem_pipelined #(
  parameter int WIDTH          = 16,
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 4096,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [WIDTH-1:0]  req_wmask,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              accept, acc_wr, acc_rd, in_range;
  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  rd_word;

  logic [RD_LAT-1:0] vld;
  logic [WIDTH-1:0]  dat [RD_LAT];

  assign accept   = req_valid & req_ready;
  assign acc_wr   = accept & req_we;
  assign acc_rd   = accept & ~req_we;
  assign in_range = ({1'b0, req_addr} < LIMIT);
  assign idx      = req_addr[IDX_W-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state)
      S_INIT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = S_IDLE;
      end
      S_IDLE: req_ready = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  // The array itself is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT)
        mem[cnt[IDX_W-1:0]] <= '0;
      else if (acc_wr && in_range)
        mem[idx] <= (mem[idx] & ~req_wmask) | (req_wdata & req_wmask);
    end
  end

  // Each stage only loads on valid data so the output holds its last response.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= acc_rd;
      if (acc_rd) dat[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign rsp_valid = vld[RD_LAT-1];
  assign rsp_rdata = dat[RD_LAT-1];

endmodule
